cam_emulator: RTL and testbench

Synthetic camera-bus transmitter. It drives the same pixel clock, 12-bit pixel, hsync and vsync lines that the capture path receives, and generates programmable test frames from the main 50 MHz clock. It is used for board loopback (its outputs are wired to the capture inputs) and as a self-checking stimulus source in simulation. It produces no register interface of its own; control is by plain ports from the surrounding glue.

---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_if.sv | 13 +
 rtl/cam_pattern.sv | 24 ++
 rtl/cam_emulator.sv | 164 ++++++++++++++++
 tb/tb_cam_emulator.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the synthetic camera-bus transmitter
// and the capture-side checker.
package cam_pkg;

   localparam int CAM_PIXEL_W = 12;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      LINE_ACTIVE = 2'd1,
      LINE_BLANK  = 2'd2,
      FRAME_BLANK = 2'd3
   } cam_state_t;

   typedef enum logic [1:0] {
      PAT_HRAMP   = 2'd0,
      PAT_DIAG    = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_FLAT    = 2'd3
   } cam_pattern_t;

endpackage

// File: rtl/cam_if.sv
// Camera bus: pixel clock, 12-bit pixel and the two sync lines.
interface cam_if;
   import cam_pkg::*;

   logic                   cam_clk;
   logic [CAM_PIXEL_W-1:0] cam_pixel;
   logic                   cam_hsync;
   logic                   cam_vsync;

   modport master (output cam_clk, output cam_pixel, output cam_hsync, output cam_vsync);
   modport slave  (input  cam_clk, input  cam_pixel, input  cam_hsync, input  cam_vsync);

endinterface

// File: rtl/cam_pattern.sv
// Test-pattern generator: pure function of position, frame number and pattern.
// Shared with the capture-side checker so both ends agree on pixel values.
module cam_pattern
   import cam_pkg::*;
(
   input  logic [CAM_PIXEL_W-1:0] x_i,
   input  logic [CAM_PIXEL_W-1:0] y_i,
   input  logic [CAM_PIXEL_W-1:0] fcnt_i,
   input  cam_pattern_t           pattern_i,
   output logic [CAM_PIXEL_W-1:0] pixel_o
);

   always_comb begin
      pixel_o = '0;
      case (pattern_i)
         PAT_HRAMP:   pixel_o = x_i;
         PAT_DIAG:    pixel_o = x_i + y_i + fcnt_i;
         PAT_CHECKER: pixel_o = (x_i[3] ^ y_i[3]) ? '1 : '0;
         PAT_FLAT:    pixel_o = 12'h800;
         default:     pixel_o = '0;
      endcase
   end

endmodule

// File: rtl/cam_emulator.sv
// Camera-bus transmitter: free-running pixel clock plus a frame/line FSM that
// advances once per pixel period (on the clk cycle where cam_clk falls).
module cam_emulator
   import cam_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 32,
   parameter int V_ACTIVE = 480,
   parameter int V_BLANK  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_count,
   cam_if.master       cam
);

   localparam int H_TOT = H_ACTIVE + H_BLANK;
   localparam int V_TOT = V_ACTIVE + V_BLANK;
   localparam int X_W   = $clog2(H_TOT);
   localparam int Y_W   = $clog2(V_TOT);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [X_W-1:0]   X_ALAST  = X_W'(H_ACTIVE - 1);
   localparam logic [X_W-1:0]   X_LAST   = X_W'(H_TOT - 1);
   localparam logic [Y_W-1:0]   Y_ALAST  = Y_W'(V_ACTIVE - 1);
   localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_TOT - 1);

   function automatic logic [CAM_PIXEL_W-1:0] to_pix_w(input logic [31:0] v);
      return v[CAM_PIXEL_W-1:0];
   endfunction

   logic [DIV_W-1:0]       div_q, div_d;
   logic                   cam_clk_q, cam_clk_d;
   cam_state_t             state_q, state_d;
   logic [X_W-1:0]         x_q, x_d;
   logic [Y_W-1:0]         y_q, y_d;
   cam_pattern_t           pat_q, pat_d;
   logic [15:0]            fcnt_q, fcnt_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;
   logic                   hsync_q, hsync_d;
   logic                   vsync_q, vsync_d;
   logic [CAM_PIXEL_W-1:0] pixel_q, pixel_d;
   logic [CAM_PIXEL_W-1:0] pat_pix;
   logic                   tick;

   cam_pattern u_pattern (
      .x_i       (to_pix_w(32'(x_d))),
      .y_i       (to_pix_w(32'(y_d))),
      .fcnt_i    (fcnt_d[CAM_PIXEL_W-1:0]),
      .pattern_i (pat_d),
      .pixel_o   (pat_pix)
   );

   always_comb begin
      div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      cam_clk_d = (div_q == DIV_LAST) ? ~cam_clk_q : cam_clk_q;
      tick      = cam_clk_q && (div_q == DIV_LAST);

      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      pat_d   = pat_q;
      fcnt_d  = fcnt_q;
      done_d  = 1'b0;

      if (tick) begin
         case (state_q)
            IDLE: begin
               if (enable) begin
                  state_d = LINE_ACTIVE;
                  x_d     = '0;
                  y_d     = '0;
                  pat_d   = cam_pattern_t'(pattern_sel);
               end
            end
            LINE_ACTIVE: begin
               x_d = x_q + 1'b1;
               if (x_q == X_ALAST) state_d = LINE_BLANK;
            end
            LINE_BLANK: begin
               if (x_q == X_LAST) begin
                  x_d     = '0;
                  y_d     = y_q + 1'b1;
                  state_d = (y_q == Y_ALAST) ? FRAME_BLANK : LINE_ACTIVE;
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
            FRAME_BLANK: begin
               if (x_q != X_LAST) begin
                  x_d = x_q + 1'b1;
               end else if (y_q != Y_LAST) begin
                  x_d = '0;
                  y_d = y_q + 1'b1;
               end else begin
                  // Frame boundary: the only point where enable and pattern_sel are sampled.
                  x_d    = '0;
                  y_d    = '0;
                  done_d = 1'b1;
                  fcnt_d = fcnt_q + 16'd1;
                  if (enable) begin
                     state_d = LINE_ACTIVE;
                     pat_d   = cam_pattern_t'(pattern_sel);
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d  = (state_d != IDLE);
      hsync_d = (state_d == LINE_ACTIVE);
      vsync_d = (state_d == LINE_ACTIVE) || (state_d == LINE_BLANK);
      pixel_d = hsync_d ? pat_pix : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q     <= '0;
         cam_clk_q <= 1'b0;
         state_q   <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         pat_q     <= PAT_HRAMP;
         fcnt_q    <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         hsync_q   <= 1'b0;
         vsync_q   <= 1'b0;
         pixel_q   <= '0;
      end else begin
         div_q     <= div_d;
         cam_clk_q <= cam_clk_d;
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         pat_q     <= pat_d;
         fcnt_q    <= fcnt_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         pixel_q   <= pixel_d;
      end
   end

   assign busy          = busy_q;
   assign frame_done    = done_q;
   assign frame_count   = fcnt_q;
   assign cam.cam_clk   = cam_clk_q;
   assign cam.cam_pixel = pixel_q;
   assign cam.cam_hsync = hsync_q;
   assign cam.cam_vsync = vsync_q;

endmodule

// File: tb/tb_cam_emulator.sv
// Scoreboard bench for cam_emulator: a small-frame instance (4x3 active) and a
// 16-pixel-wide instance for the checker pattern, sharing clock and reset.
module tb_cam_emulator;
   import cam_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0, en16 = 1'b0;
   logic [1:0]  psel = 2'd0, psel16 = 2'd0;
   logic        busy, fdone, busy16, fdone16;
   logic [15:0] fcnt, fcnt16;

   cam_if cam ();
   cam_if cam16 ();

   always #5 clk = ~clk;

   cam_emulator #(.CLK_DIV(2), .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .V_BLANK(1)) dut (
      .clk(clk), .rst(rst_n), .enable(enable), .pattern_sel(psel),
      .busy(busy), .frame_done(fdone), .frame_count(fcnt), .cam(cam));

   cam_emulator #(.CLK_DIV(2), .H_ACTIVE(16), .H_BLANK(2), .V_ACTIVE(3), .V_BLANK(1)) dut16 (
      .clk(clk), .rst(rst_n), .enable(en16), .pattern_sel(psel16),
      .busy(busy16), .frame_done(fdone16), .frame_count(fcnt16), .cam(cam16));

   int n_chk = 0;
   int n_fail = 0;
   logic [11:0] q[$];
   logic [11:0] q16[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: per-period statistics sampled at each cam_clk rising edge.
   int busy_per = 0, vs_per = 0, hs_per = 0, hs_lines = 0, fd_cnt = 0, busy_falls = 0;
   logic prev_cc = 1'b0, prev_hs = 1'b0, prev_busy = 1'b0, prev_cc16 = 1'b0;
   logic [11:0] e, e16;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_cc = 1'b0; prev_hs = 1'b0; prev_busy = 1'b0;
      end else begin
         if (!busy && prev_busy) busy_falls++;
         prev_busy = busy;
         if (fdone) fd_cnt++;
         if (cam.cam_clk && !prev_cc) begin
            if (busy) busy_per++;
            if (cam.cam_vsync) vs_per++;
            if (cam.cam_hsync) begin
               hs_per++;
               if (!prev_hs) hs_lines++;
               if (q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL pixel: got unexpected 0x%0h, expected none (t=%0t)", cam.cam_pixel, $time);
               end else begin
                  e = q.pop_front();
                  chk("pixel", 32'(cam.cam_pixel), 32'(e));
               end
            end
            prev_hs = cam.cam_hsync;
         end
         prev_cc = cam.cam_clk;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_cc16 = 1'b0;
      end else begin
         if (cam16.cam_clk && !prev_cc16 && cam16.cam_hsync) begin
            if (q16.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL pixel16: got unexpected 0x%0h, expected none (t=%0t)", cam16.cam_pixel, $time);
            end else begin
               e16 = q16.pop_front();
               chk("pixel16", 32'(cam16.cam_pixel), 32'(e16));
            end
         end
         prev_cc16 = cam16.cam_clk;
      end
   end

   task automatic wait_busy(input logic want, input int maxc, input string nm);
      int k = 0;
      while (busy !== want && k < maxc) begin @(negedge clk); k++; end
      chk(nm, 32'(busy), 32'(want));
   endtask

   task automatic wait_busy16(input logic want, input int maxc, input string nm);
      int k = 0;
      while (busy16 !== want && k < maxc) begin @(negedge clk); k++; end
      chk(nm, 32'(busy16), 32'(want));
   endtask

   task automatic push_ramp_frame();
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 4; x++) q.push_back(12'(x));
   endtask

   task automatic push_diag_frame(input int fc);
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 4; x++) q.push_back(12'(x + y + fc));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
      $fatal(1);
   end

   int b_busy, b_vs, b_hs, b_lines, b_fd, b_falls, k;
   logic [31:0] cc_exp [8];

   initial begin
      cc_exp = '{0, 1, 1, 0, 0, 1, 1, 0};

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_cam_clk", 32'(cam.cam_clk), 0);
      chk("rst_hsync", 32'(cam.cam_hsync), 0);
      chk("rst_vsync", 32'(cam.cam_vsync), 0);
      chk("rst_pixel", 32'(cam.cam_pixel), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_done", 32'(fdone), 0);
      chk("rst_frame_count", 32'(fcnt), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("cam_clk_run%0d", i), 32'(cam.cam_clk), cc_exp[i]);
      end

      // Single frame, h-ramp
      b_busy = busy_per; b_vs = vs_per; b_hs = hs_per; b_lines = hs_lines; b_fd = fd_cnt;
      push_ramp_frame();
      psel = 2'd0; enable = 1'b1;
      wait_busy(1'b1, 20, "start_frame1");
      enable = 1'b0;
      wait_busy(1'b0, 200, "end_frame1");
      repeat (4) @(negedge clk);
      chk("f1_hsync_periods", 32'(hs_per - b_hs), 12);
      chk("f1_hsync_lines", 32'(hs_lines - b_lines), 3);
      chk("f1_vsync_periods", 32'(vs_per - b_vs), 18);
      chk("f1_busy_periods", 32'(busy_per - b_busy), 24);
      chk("f1_frame_done", 32'(fd_cnt - b_fd), 1);
      chk("f1_frame_count", 32'(fcnt), 1);
      chk("f1_queue_left", 32'(q.size()), 0);

      // Diagonal, continuous, enable dropped during line 1 of the second frame
      b_busy = busy_per; b_vs = vs_per; b_fd = fd_cnt; b_falls = busy_falls;
      push_diag_frame(1);
      push_diag_frame(2);
      psel = 2'd1; enable = 1'b1;
      wait_busy(1'b1, 20, "start_diag");
      k = 0;
      while (fcnt !== 16'd2 && k < 200) begin @(negedge clk); k++; end
      chk("diag_frame_count_mid", 32'(fcnt), 2);
      chk("diag_busy_at_boundary", 32'(busy), 1);
      repeat (28) @(negedge clk);
      enable = 1'b0;
      psel = 2'd0;
      wait_busy(1'b0, 200, "end_diag");
      repeat (4) @(negedge clk);
      chk("diag_frame_count", 32'(fcnt), 3);
      chk("diag_busy_periods", 32'(busy_per - b_busy), 48);
      chk("diag_busy_falls", 32'(busy_falls - b_falls), 1);
      chk("diag_frame_done", 32'(fd_cnt - b_fd), 2);
      chk("diag_vsync_periods", 32'(vs_per - b_vs), 36);
      chk("diag_queue_left", 32'(q.size()), 0);

      // Checker then flat on the wide instance; pattern change lands mid-frame
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 16; x++) q16.push_back(((x >> 3) & 1) != 0 ? 12'hFFF : 12'h000);
      for (int i = 0; i < 48; i++) q16.push_back(12'h800);
      psel16 = 2'd2; en16 = 1'b1;
      wait_busy16(1'b1, 20, "start_checker");
      repeat (100) @(negedge clk);
      psel16 = 2'd3;
      k = 0;
      while (fcnt16 !== 16'd1 && k < 400) begin @(negedge clk); k++; end
      chk("checker_frame_count_mid", 32'(fcnt16), 1);
      repeat (40) @(negedge clk);
      en16 = 1'b0;
      wait_busy16(1'b0, 400, "end_flat");
      repeat (4) @(negedge clk);
      chk("flat_frame_count", 32'(fcnt16), 2);
      chk("checker_queue_left", 32'(q16.size()), 0);

      // Reset in the middle of an active line at x=2
      q.push_back(12'd0); q.push_back(12'd1); q.push_back(12'd2);
      psel = 2'd0; enable = 1'b1;
      wait_busy(1'b1, 20, "start_pre_reset");
      enable = 1'b0;
      k = 0;
      while (q.size() != 0 && k < 100) begin @(negedge clk); k++; end
      chk("pre_reset_queue", 32'(q.size()), 0);
      chk("pre_reset_pixel", 32'(cam.cam_pixel), 2);
      chk("pre_reset_hsync", 32'(cam.cam_hsync), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_cam_clk", 32'(cam.cam_clk), 0);
      chk("mid_rst_hsync", 32'(cam.cam_hsync), 0);
      chk("mid_rst_vsync", 32'(cam.cam_vsync), 0);
      chk("mid_rst_pixel", 32'(cam.cam_pixel), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_frame_done", 32'(fdone), 0);
      chk("mid_rst_frame_count", 32'(fcnt), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_frame_count", 32'(fcnt), 0);
      push_ramp_frame();
      enable = 1'b1;
      wait_busy(1'b1, 20, "start_post_reset");
      enable = 1'b0;
      wait_busy(1'b0, 200, "end_post_reset");
      repeat (4) @(negedge clk);
      chk("post_rst_frame_count_end", 32'(fcnt), 1);
      chk("post_rst_queue_left", 32'(q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
